// File: rtl/accumulator_nch.sv
// Multi-channel unsigned accumulator with a single-entry registered result port.
// Define ACCUM_SATURATE_EN to saturate on overflow instead of wrapping.
module accumulator_nch #(
  parameter  int WIDTH    = 8,
  parameter  int CHANNELS = 4,
  localparam int CH_W     = $clog2(CHANNELS)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CH_W-1:0]     in_ch,
  input  logic                accumulate,
  input  logic                clear,
  input  logic [WIDTH-1:0]    in_data,
  input  logic                clear_all,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CH_W-1:0]     out_ch,
  output logic [WIDTH-1:0]    out_data,
  output logic                out_carry,
  output logic [CHANNELS-1:0] ovf_flags
);

  logic [WIDTH-1:0]    acc_q [CHANNELS];
  logic [WIDTH-1:0]    acc_d [CHANNELS];
  logic [CHANNELS-1:0] ovf_q, ovf_d;
  logic                outValid_q, outValid_d;
  logic [CH_W-1:0]     outCh_q, outCh_d;
  logic [WIDTH-1:0]    outData_q, outData_d;
  logic                outCarry_q, outCarry_d;

  logic                chLegal;
  logic [WIDTH-1:0]    curVal;
  logic [WIDTH:0]      sum;
  logic [WIDTH-1:0]    sumRes;
  logic                cmdFire;

  assign in_ready = !outValid_q || out_ready;

  // Channel decode: an unmatched in_ch (only possible for non power-of-two counts) is illegal.
  always_comb begin
    chLegal = 1'b0;
    curVal  = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (in_ch == c[CH_W-1:0]) begin
        chLegal = 1'b1;
        curVal  = acc_q[c];
      end
    end
  end

  assign sum = {1'b0, curVal} + {1'b0, in_data};

`ifdef ACCUM_SATURATE_EN
  assign sumRes = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
  assign sumRes = sum[WIDTH-1:0];
`endif

  assign cmdFire = in_valid && in_ready && chLegal;

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      acc_d[c] = acc_q[c];
    end
    ovf_d      = ovf_q;
    outValid_d = outValid_q;
    outCh_d    = outCh_q;
    outData_d  = outData_q;
    outCarry_d = outCarry_q;

    if (outValid_q && out_ready) begin
      outValid_d = 1'b0;
    end

    if (cmdFire) begin
      outValid_d = 1'b1;
      outCh_d    = in_ch;
      if (clear) begin
        outData_d  = '0;
        outCarry_d = 1'b0;
      end else if (accumulate) begin
        outData_d  = sumRes;
        outCarry_d = sum[WIDTH];
      end else begin
        outData_d  = curVal;
        outCarry_d = 1'b0;
      end
      for (int c = 0; c < CHANNELS; c++) begin
        if (in_ch == c[CH_W-1:0]) begin
          if (clear) begin
            acc_d[c] = '0;
            ovf_d[c] = 1'b0;
          end else if (accumulate) begin
            acc_d[c] = sumRes;
            if (sum[WIDTH]) begin
              ovf_d[c] = 1'b1;
            end
          end
        end
      end
    end

    // A global clear wins over the command, but the command still reports (as zero).
    if (clear_all) begin
      for (int c = 0; c < CHANNELS; c++) begin
        acc_d[c] = '0;
      end
      ovf_d = '0;
      if (cmdFire) begin
        outData_d  = '0;
        outCarry_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int c = 0; c < CHANNELS; c++) begin
        acc_q[c] <= '0;
      end
      ovf_q      <= '0;
      outValid_q <= 1'b0;
      outCh_q    <= '0;
      outData_q  <= '0;
      outCarry_q <= 1'b0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        acc_q[c] <= acc_d[c];
      end
      ovf_q      <= ovf_d;
      outValid_q <= outValid_d;
      outCh_q    <= outCh_d;
      outData_q  <= outData_d;
      outCarry_q <= outCarry_d;
    end
  end

  assign out_valid = outValid_q;
  assign out_ch    = outCh_q;
  assign out_data  = outData_q;
  assign out_carry = outCarry_q;
  assign ovf_flags = ovf_q;

endmodule

// File: tb/tb_accumulator_nch.sv
// Self-checking bench for accumulator_nch: directed scenarios plus random traffic
// checked against a behavioural model; a second 3-channel instance covers illegal channels.
module tb_accumulator_nch;

  localparam int W   = 8;
  localparam int NCH = 4;
  localparam int MAXV = (1 << W) - 1;

  logic       clock = 1'b0;
  logic       reset;
  logic       in_valid, in_ready, accumulate, clear, clear_all;
  logic [1:0] in_ch;
  logic [7:0] in_data;
  logic       out_valid, out_ready, out_carry;
  logic [1:0] out_ch;
  logic [7:0] out_data;
  logic [3:0] ovf_flags;

  logic       d2Reset, d2InValid, d2InReady, d2Accumulate, d2Clear, d2ClearAll;
  logic [1:0] d2InCh;
  logic [7:0] d2InData;
  logic       d2OutValid, d2OutReady, d2OutCarry;
  logic [1:0] d2OutCh;
  logic [7:0] d2OutData;
  logic [2:0] d2Ovf;

  int checkCount = 0;
  int errorCount = 0;

  int         mAcc [NCH];
  logic [3:0] mOvf;
  logic       mValid;
  int         mCh, mData;
  logic       mCarry;

  always #5 clock = ~clock;

  accumulator_nch #(.WIDTH(W), .CHANNELS(NCH)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_ch(in_ch), .accumulate(accumulate), .clear(clear), .in_data(in_data),
    .clear_all(clear_all), .out_valid(out_valid), .out_ready(out_ready),
    .out_ch(out_ch), .out_data(out_data), .out_carry(out_carry), .ovf_flags(ovf_flags)
  );

  accumulator_nch #(.WIDTH(W), .CHANNELS(3)) dut3 (
    .clock(clock), .reset(d2Reset), .in_valid(d2InValid), .in_ready(d2InReady),
    .in_ch(d2InCh), .accumulate(d2Accumulate), .clear(d2Clear), .in_data(d2InData),
    .clear_all(d2ClearAll), .out_valid(d2OutValid), .out_ready(d2OutReady),
    .out_ch(d2OutCh), .out_data(d2OutData), .out_carry(d2OutCarry), .ovf_flags(d2Ovf)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checkCount++;
    if (obs !== expv) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Reference behaviour of one clock edge, stated directly from the command rules.
  task automatic modelStep(input logic v, input int ch, input logic accm, input logic clr,
                           input int data, input logic clrAll, input logic oRdy, input logic rst);
    logic accepted, produced;
    int   s;
    if (rst) begin
      for (int c = 0; c < NCH; c++) mAcc[c] = 0;
      mOvf = '0; mValid = 0; mCh = 0; mData = 0; mCarry = 0;
      return;
    end
    accepted = v && (!mValid || oRdy);
    produced = 0;
    if (mValid && oRdy) mValid = 0;
    if (accepted && ch < NCH) begin
      produced = 1;
      mValid = 1;
      mCh = ch;
      if (clr) begin
        mAcc[ch] = 0; mOvf[ch] = 0; mData = 0; mCarry = 0;
      end else if (accm) begin
        s = mAcc[ch] + data;
        mCarry = (s > MAXV);
`ifdef ACCUM_SATURATE_EN
        mAcc[ch] = (s > MAXV) ? MAXV : s;
`else
        mAcc[ch] = s % (MAXV + 1);
`endif
        if (mCarry) mOvf[ch] = 1;
        mData = mAcc[ch];
      end else begin
        mData = mAcc[ch]; mCarry = 0;
      end
    end
    if (clrAll) begin
      for (int c = 0; c < NCH; c++) mAcc[c] = 0;
      mOvf = '0;
      if (produced) begin
        mData = 0; mCarry = 0;
      end
    end
  endtask

  // Called at a falling edge: drive one cycle of inputs, then check the registered result.
  task automatic applyStimulus(input logic v, input int ch, input logic accm, input logic clr,
                               input int data, input logic clrAll, input logic oRdy, input logic rst);
    in_valid = v; in_ch = ch[1:0]; accumulate = accm; clear = clr;
    in_data = data[7:0]; clear_all = clrAll; out_ready = oRdy; reset = rst;
    #1;
    checkOutput("in_ready", {31'd0, in_ready}, {31'd0, (!mValid || oRdy)});
    modelStep(v, ch, accm, clr, data, clrAll, oRdy, rst);
    @(posedge clock);
    @(negedge clock);
    checkOutput("out_valid", {31'd0, out_valid}, {31'd0, mValid});
    checkOutput("ovf_flags", {28'd0, ovf_flags}, {28'd0, mOvf});
    if (mValid) begin
      checkOutput("out_ch", {30'd0, out_ch}, mCh);
      checkOutput("out_data", {24'd0, out_data}, mData);
      checkOutput("out_carry", {31'd0, out_carry}, {31'd0, mCarry});
    end
  endtask

  initial begin
    int expWrap;
    d2Reset = 1; d2InValid = 0; d2InCh = 0; d2Accumulate = 0; d2Clear = 0;
    d2InData = 0; d2ClearAll = 0; d2OutReady = 1;
    @(negedge clock);

    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);
    checkOutput("reset_data", {24'd0, out_data}, 0);
    checkOutput("reset_ch", {30'd0, out_ch}, 0);
    checkOutput("reset_carry", {31'd0, out_carry}, 0);

    // ch0 200 then 100 overflows
    applyStimulus(1, 0, 1, 0, 200, 0, 1, 0);
    checkOutput("req028_first", {24'd0, out_data}, 200);
    applyStimulus(1, 0, 1, 0, 100, 0, 1, 0);
`ifdef ACCUM_SATURATE_EN
    expWrap = 255;
`else
    expWrap = 44;
`endif
    checkOutput("req028_second", {24'd0, out_data}, expWrap);
    checkOutput("req028_carry", {31'd0, out_carry}, 1);
    checkOutput("req028_ovf0", {31'd0, ovf_flags[0]}, 1);

    // clear has priority over accumulate
    applyStimulus(1, 2, 1, 0, 7, 0, 1, 0);
    applyStimulus(1, 2, 1, 1, 5, 0, 1, 0);
    checkOutput("req029_data", {24'd0, out_data}, 0);
    applyStimulus(1, 2, 0, 0, 0, 0, 1, 0);
    checkOutput("req029_read", {24'd0, out_data}, 0);
    checkOutput("req029_ovf2", {31'd0, ovf_flags[2]}, 0);

    // Backpressure: result on ch1 held for three cycles
    applyStimulus(1, 1, 1, 0, 3, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 1, 0, 9, 0, 0, 0);
      checkOutput("req030_hold_ch", {30'd0, out_ch}, 1);
    end
    applyStimulus(1, 0, 1, 0, 9, 0, 1, 0);
    checkOutput("req030_next_ch", {30'd0, out_ch}, 0);

    // Back-to-back on ch3
    applyStimulus(1, 3, 0, 1, 0, 0, 1, 0);
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1, 3, 1, 0, 1, 0, 1, 0);
      checkOutput("req031_seq", {24'd0, out_data}, i);
    end

    // Command alongside clear_all, then reset with a pending result
    applyStimulus(1, 1, 1, 0, 50, 1, 1, 0);
    checkOutput("req032_data", {24'd0, out_data}, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    checkOutput("req032_valid", {31'd0, out_valid}, 0);
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);
    checkOutput("req032_read1", {24'd0, out_data}, 0);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 1),
                    $urandom_range(0, 7) == 0, $urandom_range(0, 255),
                    $urandom_range(0, 31) == 0, $urandom_range(0, 2) != 0,
                    $urandom_range(0, 99) == 0);
    end

    // Three-channel instance: in_ch=3 is illegal
    @(negedge clock);
    d2Reset = 0; d2InValid = 1; d2InCh = 0; d2Accumulate = 1; d2InData = 5;
    @(posedge clock); @(negedge clock);
    checkOutput("ch3_legal_valid", {31'd0, d2OutValid}, 1);
    checkOutput("ch3_legal_data", {24'd0, d2OutData}, 5);
    d2InCh = 3; d2InData = 9;
    @(posedge clock); @(negedge clock);
    checkOutput("ch3_illegal_valid", {31'd0, d2OutValid}, 0);
    checkOutput("ch3_illegal_ovf", {29'd0, d2Ovf}, 0);
    d2InCh = 0; d2Accumulate = 0;
    @(posedge clock); @(negedge clock);
    checkOutput("ch3_readback", {24'd0, d2OutData}, 5);
    d2InValid = 0;

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/accumulator_nch.md
ACCUMULATOR_NCH -- requirements
Module: accumulator_nch

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data and accumulator width in bits (>=2).
REQ-002 SHALL have parameter CHANNELS, default 4, number of independent accumulators (>=2); CH_W = clog2(CHANNELS), derived localparam.
REQ-003 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  command present.
REQ-006 SHALL have port in_ready  output  1  command accepted when in_valid && in_ready.
REQ-007 SHALL have port in_ch  input  CH_W  target channel; values >= CHANNELS illegal, command dropped with no state change and no output.
REQ-008 SHALL have port accumulate  input  1  add in_data to channel.
REQ-009 SHALL have port clear  input  1  zero channel (priority over accumulate).
REQ-010 SHALL have port in_data  input  WIDTH  unsigned addend.
REQ-011 SHALL have port clear_all  input  1  zero all channels and all sticky flags; no handshake required.
REQ-012 SHALL have port out_valid  output  1  result held in output register.
REQ-013 SHALL have port out_ready  input  1  consumer takes result when out_valid && out_ready.
REQ-014 SHALL have ports out_ch (CH_W), out_data (WIDTH), out_carry (1)  outputs  channel, new accumulator value, carry of that operation.
REQ-015 SHALL have port ovf_flags  output  CHANNELS  sticky per-channel overflow flags.

Function
REQ-016 SHALL assert in_ready = !out_valid || out_ready (single-entry output skid, combinational from register state and out_ready).
REQ-017 On accepted command with clear=1: channel <= 0, out_data=0, out_carry=0, channel's sticky flag cleared.
REQ-018 On accepted command with clear=0, accumulate=1: sum = acc[in_ch] + in_data computed WIDTH+1 bits; acc[in_ch] <= result per REQ-027; out_carry = sum[WIDTH]; sticky flag set if carry.
REQ-019 On accepted command with clear=0, accumulate=0: channel unchanged; output carries current value (read), out_carry=0.
REQ-020 Every accepted legal command SHALL load out_valid=1, out_ch, out_data, out_carry on the same edge as the accumulator update (latency 1 cycle).
REQ-021 out_valid SHALL drop on the edge where out_valid && out_ready && no new command accepted; output fields SHALL be stable while out_valid && !out_ready.
REQ-022 Back-to-back commands to the same channel SHALL each see the value written by the previous command (no hazard, no bubble).
REQ-023 clear_all SHALL take effect on its edge, overriding any command accepted that cycle (command still produces output with out_data=0, out_carry=0).
REQ-024 Channels not addressed SHALL hold their value.

Reset
REQ-025 While reset=1 at a rising edge: all accumulators 0, ovf_flags 0, out_valid 0, out_ch 0, out_data 0, out_carry 0; any command that cycle ignored.
REQ-026 Reset mid-stream SHALL discard an unconsumed output; in_ready=1 in the first cycle after reset deasserts.

Configuration
REQ-027 Macro ACCUM_SATURATE_EN: when defined, on carry the accumulator and out_data SHALL saturate at 2^WIDTH-1; when undefined, they SHALL wrap to sum[WIDTH-1:0]. out_carry and sticky flag behave identically in both builds.

Verification
REQ-028 WIDTH=8: ch0 accumulate 200 then 100 -> outputs 200 (carry 0), then 44 wrap / 255 saturate, carry 1, ovf_flags[0]=1.
REQ-029 clear=1 and accumulate=1, in_data=5 on ch2 holding 7 -> out_data 0, acc[2]=0, ovf_flags[2]=0.
REQ-030 out_ready held 0 for 3 cycles after result on ch1 -> in_ready=0, out fields stable; out_ready=1 -> next command accepted same cycle.
REQ-031 Back-to-back ch3 accumulate 1,1,1 with out_ready=1 -> out_data 1,2,3 on consecutive cycles.
REQ-032 Command in same cycle as clear_all, then reset asserted with out_valid=1 -> output 0 with all channels zero; after reset out_valid=0, ovf_flags=0, in_ready=1.
REQ-033 CHANNELS=3, in_ch=3 accepted -> no output, no state change.
